fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage, successor to the single-cycle `if_stage` PC register. It owns the fetch PC and issues requests to instruction memory through a request/grant/response handshake. Returned instructions are buffered with their PCs in a DEPTH-entry queue and delivered to decode over a valid/ready interface. Branch, JAL and JALR redirects arrive from execute; a redirect flushes the queue and drops any in-flight fetch.

## Interface
- N, 32: address and data width.
- DEPTH, 4: fetch-queue entries; power of two, ≥2.
- RESET_PC, 0: fetch PC loaded on reset.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  N  fetch address; equals the fetch PC.
- imem_gnt  in  1  request accepted this cycle (`imem_req && imem_gnt`).
- imem_rvalid  in  1  response valid, at least 1 cycle after the grant.
- imem_rdata  in  N  fetched instruction.
- if_valid  out  1  queue head valid to decode.
- if_pc  out  N  PC of the queue head.
- if_instr  out  N  instruction at the queue head.
- id_ready  in  1  decode accepts the head when `if_valid && id_ready`.
- opcode  in  7  opcode of the instruction in execute.
- and_out  in  1  branch condition result from execute.
- ex_pc  in  N  PC of the instruction in execute.
- ex_rs1  in  N  rs1 value, used for JALR.
- pc_signed_offset  in  N  sign-extended immediate.
- redirect  out  1  combinational redirect-taken flag.
- pc_new  out  N  link address, `ex_pc + 4`, combinational.

## Operation
- **Redirect taken** when any of the following holds:
  - `opcode == 1101111` (JAL).
  - `opcode == 1100111` (JALR).
  - `opcode == 1100011 && and_out` (branch taken).
  - Every other opcode, including `1111111`, gives no redirect.
- **Redirect target**:
  - JAL/branch: `ex_pc + pc_signed_offset`.
  - JALR: `(ex_rs1 + pc_signed_offset) & ~1`.
  - All sums are modulo 2^N; negative offsets wrap correctly.
- **Fetch FSM states**:
  - RUN: no request outstanding.
  - WAIT: a granted request is outstanding.
  - DROP: the outstanding request belongs to a flushed path.
- **Request issue**: `imem_req = !reset && !redirect && space && (state==RUN || (state==WAIT && imem_rvalid))`, where `space = count + (state!=RUN) < DEPTH`. Pops in the same cycle give no credit.
- **On grant**: fetch PC += 4 and state goes to WAIT. Without a grant, imem_req and imem_addr hold.
- **WAIT + imem_rvalid, no redirect**: push {PC of the request, imem_rdata}. Go to WAIT if a new grant occurs that cycle, else RUN.
- **Redirect** has priority over every other event in that cycle:
  - Fetch PC is loaded with the target.
  - The queue is cleared and any same-cycle pop or push is discarded.
  - Next state: WAIT without rvalid goes to DROP; WAIT with rvalid goes to RUN (data dropped); DROP stays DROP unless rvalid that cycle, then RUN; RUN stays RUN.
- **DROP + imem_rvalid**: data is discarded and state goes to RUN.
- **Queue**: circular buffer with N-bit-PC and N-bit-instruction fields. Read and write pointers wrap modulo DEPTH, and the count runs 0..DEPTH.
  - Simultaneous push and pop leave count unchanged.
  - Push when full cannot occur (guarded by space); an rvalid in RUN is a protocol error and is ignored.
- **Reset** (including mid-operation) takes effect at the next edge:
  - Fetch PC = RESET_PC, state = RUN, queue empty.
  - Outstanding responses are forgotten; rvalid arriving in RUN is ignored.
- **Reset values of outputs**:
  - imem_req = 0 while reset is high.
  - imem_addr = RESET_PC.
  - if_valid = 0.
  - if_pc and if_instr = 0.
  - redirect and pc_new follow their inputs combinationally.

## Timing
- **First fetch**: reset is low at edge 0; imem_req is high with addr RESET_PC in cycle 0.
- **Fetch-to-decode latency**: grant in cycle k, rvalid in cycle k+1, if_valid in cycle k+2 (queue output is registered).
- **Throughput**: one instruction per cycle when rvalid always follows the grant by 1 cycle and decode is always ready.
- **Redirect latency**: redirect in cycle r puts imem_req to the target in cycle r+1 if state is RUN. If state is DROP, the request waits for the stale rvalid.
- **Flush timing**: if_valid is 0 in cycle r+1, and no stale instruction ever reaches decode after a redirect.
- **Backpressure**: with id_ready low, the queue fills to DEPTH and imem_req then stays low. Fetch resumes the cycle after a pop frees space.

## Test plan
- **Reset and stream**: reset 2 cycles, gnt=1, rvalid 1 cycle later, id_ready=1 → decode receives PCs 0,4,8,12 on consecutive cycles with the matching rdata.
- **JAL**: JAL with ex_pc=0x10, offset=100 → redirect=1, pc_new=0x14, next imem_addr=0x74, queue empty next cycle.
- **JALR and branch**: JALR with ex_rs1=0x201, offset=120 → target 0x278 (bit 0 cleared). Branch ex_pc=0x40, offset=-8, and_out=1 → target 0x38. Same branch with and_out=0 → no redirect, sequential PCs.
- **Redirect during WAIT**: redirect while a fetch is outstanding, rvalid 3 cycles later → that data is never on if_instr, and the first post-redirect if_pc equals the target.
- **Backpressure**: DEPTH=4, id_ready=0 for 10 cycles → exactly 4 entries queued, imem_req low. Raising id_ready drains them in order, then fetch resumes.
- **Glitchy and invalid-opcode reset**: opcode 1111111 gives no redirect. A 1-cycle reset pulse mid-stream → imem_addr=RESET_PC and if_valid=0 the next cycle; a pending rvalid is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives imem over req/gnt/rvalid,
// queues returned {pc, instr} pairs for decode and applies execute redirects.
module fetch_unit #(
  parameter int unsigned  N        = 32,
  parameter int unsigned  DEPTH    = 4,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         if_valid,
  output logic [N-1:0] if_pc,
  output logic [N-1:0] if_instr,
  input  logic         id_ready,
  input  logic [6:0]   opcode,
  input  logic         and_out,
  input  logic [N-1:0] ex_pc,
  input  logic [N-1:0] ex_rs1,
  input  logic [N-1:0] pc_signed_offset,
  output logic         redirect,
  output logic [N-1:0] pc_new
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [N-1:0] PC_STEP = N'(4);
  localparam logic [N-1:0] LSB_CLR = ~(N'(1));
  localparam logic [6:0]   OP_JAL  = 7'b1101111;
  localparam logic [6:0]   OP_JALR = 7'b1100111;
  localparam logic [6:0]   OP_BR   = 7'b1100011;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [N-1:0]   req_pc_q, req_pc_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   mem_pc_q    [DEPTH];
  logic [N-1:0]   mem_instr_q [DEPTH];

  logic [N-1:0]   target;
  logic [N-1:0]   jalr_sum;
  logic [CW:0]    occ;
  logic           space, grant, push, pop;

  always_comb begin
    redirect = (opcode == OP_JAL) || (opcode == OP_JALR) ||
               ((opcode == OP_BR) && and_out);
    jalr_sum = ex_rs1 + pc_signed_offset;
    target   = (opcode == OP_JALR) ? (jalr_sum & LSB_CLR) : (ex_pc + pc_signed_offset);
    pc_new   = ex_pc + PC_STEP;
  end

  // An outstanding request already owns one queue slot; pops never free one early.
  always_comb begin
    occ      = {1'b0, count_q} + {{CW{1'b0}}, (state_q != S_RUN)};
    space    = occ < DEPTH_C;
    imem_req = !reset && !redirect && space &&
               ((state_q == S_RUN) || ((state_q == S_WAIT) && imem_rvalid));
    grant    = imem_req && imem_gnt;
    push     = !reset && !redirect && (state_q == S_WAIT) && imem_rvalid;
    pop      = !redirect && if_valid && id_ready;
  end

  assign imem_addr = pc_q;
  assign if_valid  = (count_q != '0);
  assign if_pc     = if_valid ? mem_pc_q[rd_ptr_q]    : '0;
  assign if_instr  = if_valid ? mem_instr_q[rd_ptr_q] : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // A granted request still in flight must have its response swallowed.
      state_d  = ((state_q == S_RUN) || imem_rvalid) ? S_RUN : S_DROP;
    end else begin
      if (grant) begin
        pc_d     = pc_q + PC_STEP;
        req_pc_d = pc_q;
        state_d  = S_WAIT;
      end else if (imem_rvalid && (state_q != S_RUN)) begin
        state_d  = S_RUN;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= req_pc_q;
      mem_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-randomised imem responder, a queue-based
// reference model checked every cycle, and directed scenarios with literal values.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          N        = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_BR    = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic [6:0]  opcode;
  logic        and_out;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] pc_signed_offset;
  logic        redirect;
  logic [31:0] pc_new;

  always #5 clk = ~clk;

  fetch_unit #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready),
    .opcode(opcode), .and_out(and_out), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .pc_signed_offset(pc_signed_offset), .redirect(redirect), .pc_new(pc_new)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // imem responder: one request at a time, response lat cycles after the grant
  bit          pend_v = 1'b0;
  logic [31:0] pend_addr;
  int          pend_cnt = 0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100, ready_pct = 100;
  bit          rand_exec = 1'b0, rand_ready = 1'b0;

  // reference model: fetch PC, decode queue, and one outstanding-fetch record
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_out = 0;      // 0 none, 1 live fetch, 2 fetch on a flushed path
  logic [31:0] m_out_pc;
  bit          m_on = 1'b0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_redirect();
    return (opcode == OP_JAL) || (opcode == OP_JALR) || ((opcode == OP_BR) && and_out);
  endfunction

  function automatic logic [31:0] exp_target();
    if (opcode == OP_JALR) return (ex_rs1 + pc_signed_offset) & 32'hFFFF_FFFE;
    return ex_pc + pc_signed_offset;
  endfunction

  function automatic bit exp_req();
    int held = m_q.size() + ((m_out != 0) ? 1 : 0);
    return !reset && !exp_redirect() && (held < DEPTH) &&
           ((m_out == 0) || ((m_out == 1) && imem_rvalid));
  endfunction

  task automatic rand_exec_inputs();
    int r;
    int off;
    r = int'($urandom_range(0, 99));
    if (r < 3)       opcode = OP_JAL;
    else if (r < 6)  opcode = OP_JALR;
    else if (r < 14) opcode = OP_BR;
    else if (r < 17) opcode = 7'h7F;
    else             opcode = 7'($urandom);
    and_out = 1'($urandom_range(0, 1));
    ex_pc   = $urandom & 32'hFFFF_FFFC;
    ex_rs1  = $urandom;
    off     = int'($urandom_range(0, 2047)) - 1024;
    pc_signed_offset = ($urandom_range(0, 3) == 0) ? $urandom : 32'(off);
    reset   = ($urandom_range(0, 199) == 0);
  endtask

  // Drive this cycle's inputs; called just after a rising edge.
  task automatic setup();
    if (pend_v && pend_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = (!pend_v || imem_rvalid) && (int'($urandom_range(0, 99)) < gnt_pct);
    if (rand_ready) id_ready = (int'($urandom_range(0, 99)) < ready_pct);
    if (rand_exec) rand_exec_inputs();
  endtask

  // Called at the falling edge: compare against the model, then advance both.
  task automatic commit();
    bit rd, rq, hs;
    if (m_on) begin
      chk1("redirect", redirect, exp_redirect());
      chk("pc_new", pc_new, ex_pc + 32'd4);
      chk1("imem_req", imem_req, exp_req());
      chk("imem_addr", imem_addr, m_pc);
      chk1("if_valid", if_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("if_pc", if_pc, m_q[0].pc);
        chk("if_instr", if_instr, m_q[0].instr);
      end
      if (!rand_exec && if_valid && id_ready && !redirect)
        $display("decode pc=%h instr=%h", if_pc, if_instr);
    end
    hs = imem_req && imem_gnt;
    if (imem_rvalid) pend_v = 1'b0;
    else if (pend_v && pend_cnt > 0) pend_cnt--;
    if (hs) begin
      pend_v    = 1'b1;
      pend_addr = imem_addr;
      pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
    end
    rd = exp_redirect();
    rq = exp_req();
    if (reset) begin
      m_pc = RESET_PC;
      m_q.delete();
      m_out = 0;
      m_on  = 1'b1;
    end else if (m_on) begin
      if (rd) begin
        m_pc = exp_target();
        m_q.delete();
        if (imem_rvalid) m_out = 0;
        else if (m_out != 0) m_out = 2;
      end else begin
        if (m_q.size() > 0 && id_ready) void'(m_q.pop_front());
        if (imem_rvalid) begin
          if (m_out == 1) m_q.push_back('{m_out_pc, imem_rdata});
          m_out = 0;
        end
        if (rq && imem_gnt) begin
          m_out    = 1;
          m_out_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    setup();
    @(negedge clk);
    commit();
  endtask

  task automatic wait_grant(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      setup();
      @(negedge clk);
      seen = imem_req && imem_gnt;
      commit();
    end
    chk1(name, seen, 1'b1);
  endtask

  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      setup();
      @(negedge clk);
      if (if_valid) begin
        seen = 1'b1;
        chk({name, "_pc"}, if_pc, exp_pc);
        chk({name, "_instr"}, if_instr, memf(exp_pc));
      end
      commit();
    end
    chk1({name, "_seen"}, seen, 1'b1);
  endtask

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b1; opcode = 7'h00; and_out = 1'b0;
    ex_pc = '0; ex_rs1 = '0; pc_signed_offset = '0;
    @(posedge clk);
    #1;
    tick();
    // second reset cycle: registers already reset
    setup();
    @(negedge clk);
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    commit();

    // reset and stream
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      setup();
      @(negedge clk);
      if (c == 0) begin
        chk1("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, RESET_PC);
      end
      if (c == 1) chk1("latency_valid", if_valid, 1'b0);
      if (c >= 2) begin
        chk1("stream_valid", if_valid, 1'b1);
        chk("stream_pc", if_pc, 32'(4 * (c - 2)));
        chk("stream_instr", if_instr, memf(32'(4 * (c - 2))));
      end
      commit();
    end

    // JAL
    opcode = OP_JAL; ex_pc = 32'h10; pc_signed_offset = 32'd100;
    setup(); @(negedge clk);
    chk1("jal_redirect", redirect, 1'b1);
    chk("jal_pc_new", pc_new, 32'h14);
    commit();
    opcode = 7'h00;
    setup(); @(negedge clk);
    chk1("jal_flush", if_valid, 1'b0);
    chk1("jal_req", imem_req, 1'b1);
    chk("jal_addr", imem_addr, 32'h74);
    commit();

    // JALR clears bit 0
    opcode = OP_JALR; ex_rs1 = 32'h201; pc_signed_offset = 32'd120;
    setup(); @(negedge clk);
    chk1("jalr_redirect", redirect, 1'b1);
    commit();
    opcode = 7'h00;
    setup(); @(negedge clk);
    chk("jalr_addr", imem_addr, 32'h278);
    commit();

    // taken branch with negative offset, then the same branch not taken
    opcode = OP_BR; and_out = 1'b1; ex_pc = 32'h40; pc_signed_offset = 32'hFFFF_FFF8;
    setup(); @(negedge clk);
    chk1("br_redirect", redirect, 1'b1);
    commit();
    opcode = 7'h00;
    setup(); @(negedge clk);
    chk("br_addr", imem_addr, 32'h38);
    commit();
    opcode = OP_BR; and_out = 1'b0;
    setup(); @(negedge clk);
    chk1("br_nt_redirect", redirect, 1'b0);
    chk("br_nt_addr0", imem_addr, 32'h3C);
    commit();
    opcode = 7'h00;
    setup(); @(negedge clk);
    chk("br_nt_addr1", imem_addr, 32'h40);
    commit();

    // redirect while a fetch is outstanding; its response lands 3 cycles after grant
    lat_min = 3; lat_max = 3;
    wait_grant("wait_grant_seen");
    opcode = OP_JAL; ex_pc = 32'h100; pc_signed_offset = 32'h200;
    setup(); @(negedge clk);
    chk1("drop_redirect", redirect, 1'b1);
    commit();
    opcode = 7'h00;
    setup(); @(negedge clk);
    chk1("drop_req", imem_req, 1'b0);
    chk1("drop_flush", if_valid, 1'b0);
    commit();
    wait_first_valid("drop_first", 32'h300);

    // backpressure: fill to DEPTH with decode stalled, then drain
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) tick();
    id_ready = 1'b0;
    opcode = OP_JAL; ex_pc = 32'h0; pc_signed_offset = 32'h400;
    tick();
    opcode = 7'h00;
    for (int i = 0; i < 10; i++) begin
      setup(); @(negedge clk);
      if (i == 9) begin
        chk1("bp_req_low", imem_req, 1'b0);
        chk("bp_addr", imem_addr, 32'h410);
        chk1("bp_valid", if_valid, 1'b1);
        chk("bp_head", if_pc, 32'h400);
      end
      commit();
    end
    id_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      setup(); @(negedge clk);
      chk("bp_drain_pc", if_pc, 32'h400 + 32'(4 * j));
      chk("bp_drain_instr", if_instr, memf(32'h400 + 32'(4 * j)));
      if (j == 0) chk1("bp_no_credit", imem_req, 1'b0);
      if (j == 1) begin
        chk1("bp_resume_req", imem_req, 1'b1);
        chk("bp_resume_addr", imem_addr, 32'h410);
      end
      commit();
    end

    // invalid opcode, then a one-cycle reset while a response is pending
    opcode = 7'h7F; and_out = 1'b1;
    setup(); @(negedge clk);
    chk1("bad_op_redirect", redirect, 1'b0);
    commit();
    opcode = 7'h00; and_out = 1'b0;
    lat_min = 2; lat_max = 2;
    wait_grant("glitch_grant_seen");
    reset = 1'b1;
    setup(); @(negedge clk);
    chk1("glitch_req", imem_req, 1'b0);
    commit();
    reset = 1'b0;
    setup(); @(negedge clk);
    chk("glitch_addr", imem_addr, RESET_PC);
    chk1("glitch_valid", if_valid, 1'b0);
    commit();
    wait_first_valid("glitch_first", RESET_PC);

    // randomized phase against the model
    lat_min = 1; lat_max = 3; gnt_pct = 70; ready_pct = 60;
    rand_ready = 1'b1; rand_exec = 1'b1;
    for (int i = 0; i < 4000; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
